icache_fetch_ctrl: RTL
======================

# icache_fetch_ctrl

Instruction-fetch controller between the IF stage, the direct-indexed instruction cache and the byte-wide memory bus arbiter. On each fetch request it checks the cache. A hit is returned in one cycle. On a miss it fetches the 32-bit instruction as four byte reads, assembles it little-endian, refills the cache and returns it. Branch redirects can abort a fetch in flight.

## Interface
Parameters: none.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; low freezes the controller
- pc_i  in  32  fetch address from IF; word-aligned
- fetch_req_i  in  1  level request to fetch at pc_i
- flush_i  in  1  branch redirect; abort current fetch
- inst_valid_o  out  1  one-cycle pulse: inst_o/pc_o valid
- inst_o  out  32  fetched instruction
- pc_o  out  32  address of inst_o
- busy_o  out  1  high when state is not IDLE
- cache_pc_read_o  out  32  lookup address to cache; combinational copy of pc_i
- cache_hit_i  in  1  combinational hit from cache
- cache_inst_i  in  32  cache read data
- cache_write_o  out  1  one-cycle refill strobe
- cache_pc_write_o  out  32  refill address
- cache_inst_o  out  32  refill data
- mem_req_o  out  1  request a byte read this cycle
- mem_gnt_i  in  1  arbiter grant; a read issues when mem_req_o && mem_gnt_i at the rising edge
- mem_addr_o  out  32  byte address; valid while mem_req_o is high
- mem_din_i  in  8  read data for the address issued in the previous cycle

## Operation
- States: IDLE, FETCH, DONE. Reset puts the controller in IDLE, with all outputs 0 and both counters cleared.
- IDLE, fetch_req_i=1, flush_i=0:
  - On a hit: latch inst_o=cache_inst_i and pc_o=pc_i, then go to DONE.
  - On a miss: latch fetch_pc=pc_i, clear issue_cnt and recv_cnt (3-bit each), then go to FETCH.
- FETCH:
  - mem_req_o = (issue_cnt<4).
  - mem_addr_o = fetch_pc + issue_cnt, computed 32-bit modulo 2^32.
  - issue_cnt increments on each granted cycle.
  - In the cycle after a granted cycle, mem_din_i is written into byte lane recv_cnt (bits 8k+7:8k), and recv_cnt increments.
  - When the 4th byte is captured, go to DONE. In the same edge, load inst_o and pc_o=fetch_pc, and set cache_write_o=1, cache_pc_write_o=fetch_pc, cache_inst_o=assembled word.
- DONE: inst_valid_o=1 for exactly this cycle. cache_write_o is also high in this cycle if DONE was entered from FETCH. Return to IDLE unconditionally; no request is accepted in DONE.
- Gaps in mem_gnt_i stall issuing only. A byte already issued is always captured.
- flush_i:
  - In IDLE: overrides fetch_req_i; nothing is accepted.
  - In FETCH: go to IDLE next cycle, clear the counters, drop mem_req_o, discard any in-flight byte, and do not write the cache.
  - In DONE: no effect; the pulse and refill still occur, and the consumer discards the pulse.
- rdy=0:
  - State, counters and latched outputs hold.
  - mem_req_o is forced to 0.
  - A byte issued in the previous cycle is still captured.
  - inst_valid_o and cache_write_o are forced to 0 and are re-asserted when rdy returns.
- rst mid-FETCH: return to IDLE immediately with no refill.

## Timing
- Hit: request accepted in cycle t, inst_valid_o=1 in cycle t+1. Throughput is one instruction per 2 cycles.
- Miss with continuous grant: miss detected in t; addresses issued in t+1..t+4; data arrives in t+2..t+5; inst_valid_o and cache_write_o are high in t+6. Miss latency is 6 cycles.
- Each cycle without a grant adds one cycle of latency.
- All outputs are registered except cache_pc_read_o, mem_req_o and mem_addr_o, which are decoded from state and registers.

## Configuration
- ICACHE_BYPASS_EN defined:
  - cache_hit_i is ignored, so every request takes the miss path.
  - cache_write_o stays 0.
  - Used for memory-path debug.
- Undefined: normal hit and refill behaviour as described above.

## Test plan
- Hit: pc_i=0x100, cache_hit_i=1, cache_inst_i=0x00500093 -> next cycle inst_valid_o=1, inst_o=0x00500093, pc_o=0x100, mem_req_o never high.
- Miss, continuous grant: pc_i=0x200, memory bytes 0x13,0x05,0x10,0x00 -> mem_addr_o 0x200..0x203 in consecutive cycles; 6 cycles after the request, inst_o=0x00100513 and cache_write_o=1 with cache_pc_write_o=0x200.
- Miss, mem_gnt_i low on the 2nd and 4th request cycles -> same data and refill, latency 8 cycles, no duplicate or skipped address.
- flush_i in FETCH after 2 bytes -> IDLE next cycle, mem_req_o=0, no cache_write_o, no inst_valid_o; a new request at 0x300 then completes correctly.
- rdy low for 3 cycles mid-FETCH -> no request issued while low, byte issued just before is kept, final inst_o correct, latency +3.
- ICACHE_BYPASS_EN with cache_hit_i=1 -> full 4-byte memory fetch, cache_write_o stays 0.

Source files
------------

// File: rtl/icache_fetch_ctrl.sv
// icache_fetch_ctrl
//   Instruction-fetch controller sitting between the IF stage, a
//   direct-indexed instruction cache and a byte-wide memory bus arbiter.
//   A cache hit is returned one cycle after the request is accepted. A miss
//   is filled with four byte reads, assembled little-endian, written back to
//   the cache and returned. A branch redirect (flush_i) aborts a miss in
//   flight without touching the cache.
//
//   Build option: define ICACHE_BYPASS_EN to ignore cache_hit_i and never
//   assert cache_write_o, so every request goes out to memory (debug aid).
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   rdy                global ready; low freezes the controller
//   pc_i, fetch_req_i  fetch address and level request from IF
//   flush_i            branch redirect
//   inst_valid_o       one-cycle pulse, inst_o/pc_o valid
//   inst_o, pc_o       returned instruction and its address
//   busy_o             controller is not idle
//   cache_pc_read_o    lookup address (copy of pc_i)
//   cache_hit_i        hit from cache, cache_inst_i its data
//   cache_write_o      refill strobe, with cache_pc_write_o/cache_inst_o
//   mem_req_o          byte read request, mem_addr_o its address
//   mem_gnt_i          arbiter grant
//   mem_din_i          byte returned the cycle after a granted request
//
// State | meaning
//   IDLE  | waiting for a fetch request; lookup done here
//   FETCH | miss in progress, issuing/capturing four byte reads
//   DONE  | result valid this cycle (plus refill strobe after a miss)

module icache_fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc_i,
  input  logic        fetch_req_i,
  input  logic        flush_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        busy_o,
  output logic [31:0] cache_pc_read_o,
  input  logic        cache_hit_i,
  input  logic [31:0] cache_inst_i,
  output logic        cache_write_o,
  output logic [31:0] cache_pc_write_o,
  output logic [31:0] cache_inst_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  input  logic [7:0]  mem_din_i
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t      state_q;
  logic [31:0] fetch_pc_q;
  logic [2:0]  issue_cnt_q;
  logic [2:0]  recv_cnt_q;
  logic        pend_q;       // a byte was granted last cycle; data is on mem_din_i now
  logic [31:0] data_q;
  logic [31:0] data_d;
  logic        valid_q;
  logic        cwrite_q;
  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic [31:0] cpcw_q;
  logic [31:0] cinst_q;

  logic hit_eff;
  logic refill_en;
  logic grant;
  logic fetch_done;
  logic flush_fetch;

`ifdef ICACHE_BYPASS_EN
  assign hit_eff   = cache_hit_i & 1'b0;
  assign refill_en = 1'b0;
`else
  assign hit_eff   = cache_hit_i;
  assign refill_en = 1'b1;
`endif

  assign cache_pc_read_o = pc_i;
  assign mem_req_o       = rdy && (state_q == FETCH) && (issue_cnt_q < 3'd4);
  assign mem_addr_o      = fetch_pc_q + {29'd0, issue_cnt_q};
  assign grant           = mem_req_o && mem_gnt_i;
  assign flush_fetch     = rdy && flush_i && (state_q == FETCH);

  // Completion covers the 4th byte arriving now, or having arrived while
  // rdy was low (recv_cnt already at 4 but the state was frozen).
  assign fetch_done = (recv_cnt_q == 3'd4) || (pend_q && (recv_cnt_q == 3'd3));

  // Pulses are held while frozen and reappear once rdy returns.
  assign inst_valid_o     = valid_q && rdy;
  assign cache_write_o    = cwrite_q && rdy;
  assign busy_o           = (state_q != IDLE);
  assign inst_o           = inst_q;
  assign pc_o             = pc_q;
  assign cache_pc_write_o = cpcw_q;
  assign cache_inst_o     = cinst_q;

  always_comb begin
    data_d = data_q;
    if (pend_q) begin
      case (recv_cnt_q)
        3'd0:    data_d[7:0]   = mem_din_i;
        3'd1:    data_d[15:8]  = mem_din_i;
        3'd2:    data_d[23:16] = mem_din_i;
        3'd3:    data_d[31:24] = mem_din_i;
        default: data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      pend_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      cwrite_q    <= 1'b0;
      inst_q      <= '0;
      pc_q        <= '0;
      cpcw_q      <= '0;
      cinst_q     <= '0;
    end else begin
      // A byte already on the bus is captured even while frozen; only a
      // redirect discards it.
      if (pend_q && !flush_fetch) begin
        data_q     <= data_d;
        recv_cnt_q <= recv_cnt_q + 3'd1;
      end
      pend_q <= grant;

      if (rdy) begin
        case (state_q)
          IDLE: begin
            if (fetch_req_i && !flush_i) begin
              if (hit_eff) begin
                inst_q  <= cache_inst_i;
                pc_q    <= pc_i;
                valid_q <= 1'b1;
                state_q <= DONE;
              end else begin
                fetch_pc_q  <= pc_i;
                issue_cnt_q <= '0;
                recv_cnt_q  <= '0;
                state_q     <= FETCH;
              end
            end
          end
          FETCH: begin
            if (flush_i) begin
              issue_cnt_q <= '0;
              recv_cnt_q  <= '0;
              pend_q      <= 1'b0;
              state_q     <= IDLE;
            end else begin
              if (grant) issue_cnt_q <= issue_cnt_q + 3'd1;
              if (fetch_done) begin
                inst_q   <= data_d;
                pc_q     <= fetch_pc_q;
                valid_q  <= 1'b1;
                cwrite_q <= refill_en;
                cpcw_q   <= fetch_pc_q;
                cinst_q  <= data_d;
                state_q  <= DONE;
              end
            end
          end
          DONE: begin
            valid_q  <= 1'b0;
            cwrite_q <= 1'b0;
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
